// File: rtl/bsg_tag_stream_decoder.sv
// Decodes the 1-bit bsg_tag serial stream into {nodeID, data_not_reset, len, payload}
// packets and queues them in a small FIFO behind a valid/yumi interface.
module bsg_tag_stream_decoder #(
  parameter  int num_clients_p       = 16,
  parameter  int max_payload_width_p = 8,
  parameter  int fifo_els_p          = 2,
  localparam int node_w = (num_clients_p > 1) ? $clog2(num_clients_p) : 1,
  localparam int len_w  = (max_payload_width_p > 0) ? $clog2(max_payload_width_p + 1) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           tag_data_i,
  output logic                           v_o,
  output logic [node_w-1:0]              node_id_o,
  output logic                           data_not_reset_o,
  output logic [len_w-1:0]               len_o,
  output logic [max_payload_width_p-1:0] payload_o,
  input  logic                           yumi_i,
  output logic                           overflow_o,
  output logic                           error_o
);

  localparam int hdr_w  = len_w + 1 + node_w;
  localparam int cnt_w  = (len_w + 1 > $clog2(hdr_w)) ? len_w + 1 : $clog2(hdr_w);
  localparam int ptr_w  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int fcnt_w = $clog2(fifo_els_p + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD
  } state_e;

  typedef struct packed {
    logic [node_w-1:0]              node;
    logic                           dnr;
    logic [len_w-1:0]               len;
    logic [max_payload_width_p-1:0] payload;
  } pkt_s;

  state_e                           r_state;
  state_e                           w_state_next;
  logic [cnt_w-1:0]                 r_cnt;
  logic [hdr_w-1:0]                 r_hdr;
  logic [max_payload_width_p-1:0]   r_payload;
  logic                             r_error;
  logic                             r_overflow;

  logic [hdr_w-1:0]                 w_hdr_next;
  logic [len_w-1:0]                 w_hdr_len;
  logic [len_w-1:0]                 w_cur_len;
  logic [max_payload_width_p-1:0]   w_payload_next;
  logic                             w_hdr_last;
  logic                             w_pay_last;
  logic                             w_push;
  logic                             w_err;
  pkt_s                             w_push_pkt;

  // Header arrives LSB first, so shifting in at the top leaves len in the low bits.
  assign w_hdr_next     = {tag_data_i, r_hdr[hdr_w-1:1]};
  assign w_hdr_len      = w_hdr_next[len_w-1:0];
  assign w_cur_len      = r_hdr[len_w-1:0];
  assign w_payload_next = r_payload | (max_payload_width_p'(tag_data_i) << r_cnt);
  assign w_hdr_last     = (r_state == S_HDR) && (r_cnt == cnt_w'(hdr_w - 1));
  assign w_pay_last     = (r_state == S_PAYLOAD) && (r_cnt == cnt_w'(w_cur_len) - cnt_w'(1));

  // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_err        = 1'b0;
    w_push_pkt   = '0;
    unique case (r_state)
      S_IDLE: if (tag_data_i) w_state_next = S_HDR;
      S_HDR: begin
        if (w_hdr_last) begin
          if (int'(w_hdr_len) > max_payload_width_p) begin
            w_err        = 1'b1;
            w_state_next = S_IDLE;
          end else if (w_hdr_len == '0) begin
            w_push          = 1'b1;
            w_push_pkt.node = w_hdr_next[hdr_w-1:len_w+1];
            w_push_pkt.dnr  = w_hdr_next[len_w];
            w_state_next    = S_IDLE;
          end else begin
            w_state_next = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_pay_last) begin
          w_push             = 1'b1;
          w_push_pkt.node    = r_hdr[hdr_w-1:len_w+1];
          w_push_pkt.dnr     = r_hdr[len_w];
          w_push_pkt.len     = w_cur_len;
          w_push_pkt.payload = w_payload_next;
          w_state_next       = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hdr     <= '0;
      r_payload <= '0;
      r_error   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_err) r_error <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (tag_data_i) r_payload <= '0;
        end
        S_HDR: begin
          r_hdr <= w_hdr_next;
          r_cnt <= w_hdr_last ? '0 : r_cnt + cnt_w'(1);
        end
        S_PAYLOAD: begin
          r_payload <= w_payload_next;
          r_cnt     <= r_cnt + cnt_w'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  pkt_s              r_mem [fifo_els_p];
  logic [ptr_w-1:0]  r_rd_ptr;
  logic [ptr_w-1:0]  r_wr_ptr;
  logic [fcnt_w-1:0] r_fcount;
  logic              w_full;
  logic              w_deq;
  logic              w_enq;
  pkt_s              w_head;

  assign v_o    = (r_fcount != '0);
  assign w_full = (r_fcount == fcnt_w'(fifo_els_p));
  assign w_deq  = yumi_i && v_o;
  // A yumi in the same cycle frees the slot, so a push to a full FIFO is still taken.
  assign w_enq  = w_push && (!w_full || w_deq);

  // NOTE: storage is not reset; occupancy and pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= w_push_pkt;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fcount   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push && !w_enq) r_overflow <= 1'b1;
      if (w_enq) r_wr_ptr <= (r_wr_ptr == ptr_w'(fifo_els_p - 1)) ? '0 : r_wr_ptr + ptr_w'(1);
      if (w_deq) r_rd_ptr <= (r_rd_ptr == ptr_w'(fifo_els_p - 1)) ? '0 : r_rd_ptr + ptr_w'(1);
      unique case ({w_enq, w_deq})
        2'b10:   r_fcount <= r_fcount + fcnt_w'(1);
        2'b01:   r_fcount <= r_fcount - fcnt_w'(1);
        default: r_fcount <= r_fcount;
      endcase
    end
  end

  assign w_head           = v_o ? r_mem[r_rd_ptr] : '0;
  assign node_id_o        = w_head.node;
  assign data_not_reset_o = w_head.dnr;
  assign len_o            = w_head.len;
  assign payload_o        = w_head.payload;
  assign overflow_o       = r_overflow;
  assign error_o          = r_error;

endmodule

// File: tb/tb_bsg_tag_stream_decoder.sv
// Directed and randomized packets driven bit-serially; a packet-level queue model
// predicts FIFO contents and sticky flags, compared every cycle.
module tb_bsg_tag_stream_decoder;

  localparam int NODE_W = 4;
  localparam int LEN_W  = 4;
  localparam int MAXP   = 8;
  localparam int ELS    = 2;
  localparam int H      = LEN_W + 1 + NODE_W;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              tag_data_i;
  logic              v_o;
  logic [NODE_W-1:0] node_id_o;
  logic              data_not_reset_o;
  logic [LEN_W-1:0]  len_o;
  logic [MAXP-1:0]   payload_o;
  logic              yumi_i;
  logic              overflow_o;
  logic              error_o;

  always #5 clk_i = ~clk_i;

  bsg_tag_stream_decoder #(
    .num_clients_p      (16),
    .max_payload_width_p(MAXP),
    .fifo_els_p         (ELS)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .tag_data_i      (tag_data_i),
    .v_o             (v_o),
    .node_id_o       (node_id_o),
    .data_not_reset_o(data_not_reset_o),
    .len_o           (len_o),
    .payload_o       (payload_o),
    .yumi_i          (yumi_i),
    .overflow_o      (overflow_o),
    .error_o         (error_o)
  );

  typedef struct {
    int unsigned node;
    int unsigned dnr;
    int unsigned len;
    int unsigned payload;
  } pkt_t;

  pkt_t model_q[$];
  bit   model_ovf;
  bit   model_err;
  int   checks;
  int   errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    pkt_t head;
    head = '{0, 0, 0, 0};
    if (model_q.size() != 0) head = model_q[0];
    check("v_o", 32'(v_o), 32'(model_q.size() != 0));
    check("node_id_o", 32'(node_id_o), head.node);
    check("data_not_reset_o", 32'(data_not_reset_o), head.dnr);
    check("len_o", 32'(len_o), head.len);
    check("payload_o", 32'(payload_o), head.payload);
    check("overflow_o", 32'(overflow_o), 32'(model_ovf));
    check("error_o", 32'(error_o), 32'(model_err));
  endtask

  // One clock: drive bit and yumi, apply the packet-level effect of this edge, then compare.
  task automatic tick(input bit b, input int ymode, input bit push, input pkt_t p, input bit err);
    tag_data_i = b;
    yumi_i = (model_q.size() != 0) && (ymode == 2 || (ymode == 1 && $urandom_range(1) == 1));
    @(posedge clk_i);
    if (yumi_i) void'(model_q.pop_front());
    if (push) begin
      if (model_q.size() < ELS) model_q.push_back(p);
      else model_ovf = 1'b1;
    end
    if (err) model_err = 1'b1;
    #1;
    check_outputs();
  endtask

  function automatic bit bit_at(input pkt_t p, input int i);
    if (i == 0) return 1'b1;
    if (i <= LEN_W) return ((p.len >> (i - 1)) & 1) != 0;
    if (i == LEN_W + 1) return p.dnr != 0;
    if (i <= H) return ((p.node >> (i - LEN_W - 2)) & 1) != 0;
    return ((p.payload >> (i - H - 1)) & 1) != 0;
  endfunction

  function automatic pkt_t mk(input int unsigned node, input int unsigned dnr,
                              input int unsigned len, input int unsigned payload);
    pkt_t p;
    p.node    = node;
    p.dnr     = dnr;
    p.len     = len;
    p.payload = payload;
    return p;
  endfunction

  task automatic send(input pkt_t p, input int ymode);
    int   n;
    pkt_t e;
    bit   bad;
    bad = p.len > MAXP;
    n = 1 + H + (bad ? 0 : int'(p.len));
    e = p;
    e.payload = bad ? 0 : (p.payload & ((1 << p.len) - 1));
    for (int i = 0; i < n; i++)
      tick(bit_at(p, i), ymode, (i == n - 1) && !bad, e, (i == n - 1) && bad);
  endtask

  task automatic send_partial(input pkt_t p, input int nbits);
    for (int i = 0; i < nbits; i++) tick(bit_at(p, i), 0, 1'b0, p, 1'b0);
  endtask

  task automatic idle(input int n, input int ymode);
    for (int i = 0; i < n; i++) tick(1'b0, ymode, 1'b0, mk(0, 0, 0, 0), 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset_i    = 1'b1;
    tag_data_i = 1'b0;
    yumi_i     = 1'b0;
    repeat (n) @(posedge clk_i);
    model_q.delete();
    model_ovf = 1'b0;
    model_err = 1'b0;
    #1;
    check_outputs();
    reset_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tag_data_i = 1'b0;
    yumi_i = 1'b0;
    do_reset(2);
    idle(3, 0);

    // Basic packet, then consume it.
    send(mk(3, 1, 8, 'hA5), 0);
    idle(1, 2);

    // Client reset packet followed by a short data packet.
    send(mk(5, 0, 8, 'hFF), 0);
    send(mk(2, 1, 3, 'b101), 0);
    idle(3, 2);

    // Zero-length packet immediately followed by a start bit.
    send(mk(7, 1, 0, 0), 0);
    send(mk(4, 1, 5, 'h13), 0);
    idle(3, 2);

    // Overflow: three back-to-back packets into a two-entry FIFO.
    send(mk(1, 1, 8, 'h11), 0);
    send(mk(2, 1, 8, 'h22), 0);
    send(mk(3, 1, 8, 'h33), 0);
    idle(2, 0);
    idle(3, 2);
    send(mk(9, 0, 7, 'h5C), 0);
    idle(2, 2);

    // Oversized length header, then a valid packet.
    send(mk(6, 1, 9, 0), 0);
    idle(2, 0);
    send(mk(1, 0, 6, 'h2A), 0);
    idle(2, 2);

    // Reset in the middle of the payload.
    send_partial(mk(12, 1, 8, 'hC3), 1 + H + 4);
    do_reset(1);
    idle(2, 0);
    send(mk(3, 1, 8, 'hA5), 0);
    idle(2, 2);

    // Randomized traffic with random consumption and gaps.
    for (int k = 0; k < 60; k++) begin
      int unsigned len;
      len = ($urandom_range(15) == 0) ? $urandom_range(15, 9) : $urandom_range(MAXP);
      send(mk($urandom_range(15), $urandom_range(1), len, $urandom_range(255)), 1);
      idle($urandom_range(3), 1);
    end
    idle(6, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
